// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I front end.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    // Canonical RV32I NOP: addi x0, x0, 0
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush empties the slot, load captures a new
// fetch, otherwise the contents hold (covers decode back-pressure).
module if_id_reg
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   load,
    input  if_id_t load_data,
    output if_id_t slot
);

    if_id_t slot_d;
    if_id_t slot_q;

    // Next slot contents: flush has priority over load; pc fields hold on flush
    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d.valid = 1'b0;
            slot_d.instr = NOP_INSTR;
        end else if (load) begin
            slot_d = load_data;
        end
    end

    // Slot register with synchronous reset to an empty NOP slot
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '{pc: '0, pc_plus4: '0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, redirect/trap FSM, fetched-instruction
// counter, and the IF/ID register feeding decode.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP,
    parameter int unsigned     COUNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [XLEN-1:0]    imem_instr,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [XLEN-1:0]    id_pc,
    output logic [XLEN-1:0]    id_pc_plus4,
    output logic [XLEN-1:0]    id_instr,
    output logic               misalign,
    output logic [XLEN-1:0]    trap_pc,
    output logic [COUNT_W-1:0] fetch_count
);

    fetch_state_t     state_d, state_q;
    logic [XLEN-1:0]  pc_d, pc_q;
    logic             misalign_d, misalign_q;
    logic [XLEN-1:0]  trap_pc_d, trap_pc_q;
    logic [COUNT_W-1:0] count_d, count_q;

    logic   slot_flush;
    logic   slot_load;
    logic   advance;
    logic   target_aligned;
    if_id_t fetched;
    if_id_t slot;

    assign imem_addr      = pc_q;
    assign advance        = !slot.valid || id_ready;
    assign target_aligned = (redirect_pc[1:0] == 2'b00);
    assign fetched        = '{pc: pc_q, pc_plus4: pc_q + 32'd4, instr: imem_instr, valid: 1'b1};

    // Next-state logic: redirect beats stall beats fetch; TRAP waits for an aligned redirect
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        trap_pc_d  = trap_pc_q;
        count_d    = count_q;
        slot_flush = 1'b0;
        slot_load  = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    slot_flush = 1'b1;
                    if (target_aligned) begin
                        pc_d = redirect_pc;
                    end else begin
                        state_d    = TRAP;
                        misalign_d = 1'b1;
                        trap_pc_d  = redirect_pc;
                    end
                end else if (advance) begin
                    slot_load = 1'b1;
                    pc_d      = pc_q + 32'd4;
                    count_d   = count_q + COUNT_W'(1);
                end
            end
            TRAP: begin
                slot_flush = 1'b1;
                if (redirect_valid) begin
                    if (target_aligned) begin
                        pc_d       = redirect_pc;
                        misalign_d = 1'b0;
                        state_d    = RUN;
                    end else begin
                        trap_pc_d = redirect_pc;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // PC, FSM, trap and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            trap_pc_q  <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            trap_pc_q  <= trap_pc_d;
            count_q    <= count_d;
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .flush     (slot_flush),
        .load      (slot_load),
        .load_data (fetched),
        .slot      (slot)
    );

    assign id_valid    = slot.valid;
    assign id_pc       = slot.pc;
    assign id_pc_plus4 = slot.pc_plus4;
    assign id_instr    = slot.instr;
    assign misalign    = misalign_q;
    assign trap_pc     = trap_pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        misalign;
    logic [31:0] trap_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [MEM_WORDS];

    // Model state
    logic [31:0] m_pc;
    logic        m_trap;
    logic        m_valid;
    logic [31:0] m_ipc, m_ipc4, m_instr;
    logic        m_mis;
    logic [31:0] m_trap_pc;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013),
        .COUNT_W   (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr),
        .misalign       (misalign),
        .trap_pc        (trap_pc),
        .fetch_count    (fetch_count)
    );

    // Combinational IMEM; addresses past the array read as NOP
    always_comb begin
        imem_instr = NOP;
        if (imem_addr < MEM_WORDS * 4) imem_instr = mem[imem_addr[7:2]];
    end

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a < MEM_WORDS * 4) return mem[a[7:2]];
        return NOP;
    endfunction

    function automatic logic [193:0] obs_vec();
        return {id_valid, id_pc, id_pc_plus4, id_instr, misalign, trap_pc, fetch_count, imem_addr};
    endfunction

    function automatic logic [193:0] exp_vec();
        return {m_valid, m_ipc, m_ipc4, m_instr, m_mis, m_trap_pc, m_cnt, m_pc};
    endfunction

    // Model of one clock edge, from the stage's documented rules
    task automatic model_edge(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        if (r) begin
            m_pc = 32'h0; m_trap = 1'b0; m_valid = 1'b0; m_instr = NOP;
            m_ipc = 32'h0; m_ipc4 = 32'h0; m_mis = 1'b0; m_trap_pc = 32'h0; m_cnt = 32'h0;
        end else if (m_trap) begin
            if (rv && rpc % 4 == 0) begin
                m_pc = rpc; m_mis = 1'b0; m_trap = 1'b0;
            end else if (rv) begin
                m_trap_pc = rpc;
            end
        end else if (rv) begin
            m_valid = 1'b0;
            m_instr = NOP;
            if (rpc % 4 == 0) m_pc = rpc;
            else begin m_trap = 1'b1; m_mis = 1'b1; m_trap_pc = rpc; end
        end else if (!m_valid || rdy) begin
            m_instr = mem_read(m_pc);
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end
    endtask

    // Drive inputs on the falling edge, advance the model, sample 1ns after the rising edge
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst = r; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
        model_edge(r, rv, rpc, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_vec() !== {1'b0, 32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec(),
                     {1'b0, 32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0, 32'h0});
        end
    endtask

    task automatic test_sequential_fetch();
        logic [31:0] words [3];
        words[0] = 32'h0050_0093; words[1] = 32'h00a0_0113; words[2] = 32'h0020_81b3;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if ({id_valid, id_pc, id_pc_plus4, id_instr} !== {1'b1, 32'(i * 4), 32'(i * 4 + 4), words[i]}) begin
                errors++;
                $display("FAIL seq_fetch[%0d] got v=%b pc=%h pc4=%h ins=%h exp pc=%h ins=%h",
                         i, id_valid, id_pc, id_pc_plus4, id_instr, 32'(i * 4), words[i]);
            end
        end
        checks++;
        if (fetch_count !== 32'd3) begin
            errors++;
            $display("FAIL seq_count got=%0d exp=3", fetch_count);
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            checks++;
            if ({id_valid, id_pc, id_instr, imem_addr, fetch_count} !== {1'b1, 32'h4, mem[1], 32'h8, 32'd2}) begin
                errors++;
                $display("FAIL stall_hold[%0d] got v=%b pc=%h ins=%h addr=%h cnt=%0d exp pc=4 addr=8 cnt=2",
                         i, id_valid, id_pc, id_instr, imem_addr, fetch_count);
            end
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h8, mem[2]}) begin
            errors++;
            $display("FAIL stall_release got v=%b pc=%h ins=%h exp pc=8 ins=%h", id_valid, id_pc, id_instr, mem[2]);
        end
    endtask

    task automatic test_redirect();
        step(1'b0, 1'b1, 32'h40, 1'b1);
        checks++;
        if ({id_valid, id_instr, imem_addr} !== {1'b0, NOP, 32'h40}) begin
            errors++;
            $display("FAIL redirect_bubble got v=%b ins=%h addr=%h exp v=0 ins=%h addr=40", id_valid, id_instr, imem_addr, NOP);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h40, mem[16]}) begin
            errors++;
            $display("FAIL redirect_target got v=%b pc=%h ins=%h exp pc=40 ins=%h", id_valid, id_pc, id_instr, mem[16]);
        end
    endtask

    task automatic test_misalign_trap();
        logic [31:0] cnt0;
        cnt0 = m_cnt;
        step(1'b0, 1'b1, 32'h42, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({misalign, trap_pc, id_valid, fetch_count} !== {1'b1, 32'h42, 1'b0, cnt0}) begin
                errors++;
                $display("FAIL trap_hold[%0d] got mis=%b tpc=%h v=%b cnt=%0d exp mis=1 tpc=42 v=0 cnt=%0d",
                         i, misalign, trap_pc, id_valid, fetch_count, cnt0);
            end
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end
        step(1'b0, 1'b1, 32'h80, 1'b1);
        checks++;
        if ({misalign, id_valid, imem_addr} !== {1'b0, 1'b0, 32'h80}) begin
            errors++;
            $display("FAIL trap_exit got mis=%b v=%b addr=%h exp mis=0 v=0 addr=80", misalign, id_valid, imem_addr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({id_valid, id_pc, fetch_count} !== {1'b1, 32'h80, cnt0 + 32'd1}) begin
            errors++;
            $display("FAIL trap_resume got v=%b pc=%h cnt=%0d exp pc=80 cnt=%0d", id_valid, id_pc, fetch_count, cnt0 + 1);
        end
    endtask

    task automatic test_redirect_in_stall();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h20, 1'b0);
        checks++;
        if ({id_valid, imem_addr} !== {1'b0, 32'h20}) begin
            errors++;
            $display("FAIL stall_redirect_flush got v=%b addr=%h exp v=0 addr=20", id_valid, imem_addr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h20, mem[8]}) begin
            errors++;
            $display("FAIL stall_redirect_fetch got v=%b pc=%h ins=%h exp pc=20 ins=%h", id_valid, id_pc, id_instr, mem[8]);
        end
    endtask

    task automatic test_wrap_and_trap_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({id_pc, id_pc_plus4, id_instr, imem_addr} !== {32'hFFFF_FFFC, 32'h0, NOP, 32'h0}) begin
            errors++;
            $display("FAIL pc_wrap got pc=%h pc4=%h ins=%h addr=%h exp pc=fffffffc pc4=0 ins=%h addr=0",
                     id_pc, id_pc_plus4, id_instr, imem_addr, NOP);
        end
        step(1'b0, 1'b1, 32'h0000_0101, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_vec() !== {1'b0, 32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL trap_reset got=%h", obs_vec());
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({id_valid, id_pc, fetch_count} !== {1'b1, 32'h0, 32'd1}) begin
            errors++;
            $display("FAIL post_reset_fetch got v=%b pc=%h cnt=%0d exp v=1 pc=0 cnt=1", id_valid, id_pc, fetch_count);
        end
    endtask

    task automatic test_random();
        logic        r, rv, rdy;
        logic [31:0] rpc;
        int          sel;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)      rpc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            else if (sel < 8) rpc = 32'($urandom_range(0, 255));
            else              rpc = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            step(r, rv, rpc, rdy);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00a0_0113;
        mem[2] = 32'h0020_81b3;
        test_reset();
        test_sequential_fetch();
        test_stall();
        test_redirect();
        test_misalign_trap();
        test_redirect_in_stall();
        test_wrap_and_trap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
